uart_paint_cmd: RTL and testbench
=================================

# uart_paint_cmd

Command decoder and responder on the host side of the UART byte interface. It consumes received bytes using the rx_avail/rx_ack handshake and parses framed paint packets. Each valid packet becomes one pixel-write or clear request toward the framebuffer writer. The block answers every completed packet with a one-byte ACK/NAK through the tx_wr/tx_busy handshake.

## Interface
- XMAX, 159: largest legal x coordinate; larger values are NAKed.
- YMAX, 119: largest legal y coordinate; larger values are NAKed.
- TIMEOUT_CYCLES, 5000000: maximum idle clk cycles between bytes of one packet.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte from the UART.
- rx_avail  in  1  received byte pending.
- rx_error  in  1  framing error pending.
- rx_ack  out  1  one-cycle pulse that consumes the pending byte or error.
- tx_data  out  8  reply byte.
- tx_wr  out  1  one-cycle pulse that starts a transmit.
- tx_busy  in  1  UART transmitter busy.
- pix_valid  out  1  request valid; held until the handshake completes.
- pix_op  out  1  0 = write pixel, 1 = clear screen with pix_color.
- pix_x  out  8  x coordinate.
- pix_y  out  8  y coordinate.
- pix_color  out  8  colour, RGB332.
- pix_ready  in  1  framebuffer writer accepts the request.
- err_cnt  out  8  saturating count of rx_error events and NAKs.

## Operation
- Packet format: SYNC 0xAA, CMD, X, Y, COLOR, CSUM.
  - CSUM = CMD ^ X ^ Y ^ COLOR.
  - CMD 0x01 = write pixel. CMD 0x02 = clear; X and Y are ignored.
- States and transitions:
  - IDLE: wait for 0xAA; every other byte is consumed and dropped.
  - CMD, X, Y, COLOR: capture one byte each, then advance.
  - CSUM: evaluate the packet.
    - Checksum match, CMD in {0x01, 0x02}, and (for 0x01) X ≤ XMAX and Y ≤ YMAX → EXEC.
    - Anything else → REPLY with tx_data = 0x15 (NAK).
  - EXEC: pix_valid = 1 until pix_valid && pix_ready, then REPLY with tx_data = 0x06 (ACK).
  - REPLY: wait for a free transmitter, pulse tx_wr, then → IDLE.
- Byte accept rule: a byte is accepted when rx_avail = 1 && rx_ack = 0 in a receiving state (IDLE through CSUM).
  - rx_ack pulses on the next cycle.
  - The rx_ack-high cycle never counts as a second accept.
- rx_error = 1 in any state:
  - pulse rx_ack; err_cnt += 1, saturating at 255.
  - in IDLE through CSUM: go to IDLE, no reply.
  - in EXEC or REPLY: finish the current packet normally.
- No bytes are consumed in EXEC or REPLY; they stay pending in the UART.
- Each NAK increments err_cnt, saturating at 255.
- pix_x, pix_y, pix_color and pix_op are registered and stable while pix_valid = 1.
- Reset values: rx_ack = 0, tx_wr = 0, tx_data = 0x00, pix_valid = 0, pix_op = 0, pix_x = 0, pix_y = 0, pix_color = 0, err_cnt = 0, state = IDLE, timeout counter = 0.

## Timing
- Reset is asynchronous.
  - Assertion mid-packet or mid-EXEC drops the packet and clears every output at once.
  - A packet is never resumed after reset.
- Byte accept at cycle n → rx_ack = 1 at n+1 → next byte accepted no earlier than n+2.
- CSUM accepted at cycle n → pix_valid = 1 at n+1, or REPLY state at n+1 on the NAK path.
- Handshake completes at cycle m → REPLY at m+1 → tx_wr at m+1 if tx_busy = 0.
- tx_wr is issued only when tx_busy = 0 and tx_wr was 0 in the previous cycle.
  - This covers the one-cycle lag before the UART raises tx_busy.
- Timeout counter:
  - width = clog2(TIMEOUT_CYCLES+1).
  - runs in CMD through CSUM; clears on each accepted byte.
  - reaching TIMEOUT_CYCLES → IDLE silently; err_cnt is not incremented.

## Configuration
- PAINT_CMD_TIMEOUT_EN
  - Defined: inter-byte timeout logic is compiled in, as described above.
  - Undefined: the counter is removed and a partial packet waits indefinitely; TIMEOUT_CYCLES is unused.

## Test plan
- Valid write: bytes AA 01 10 20 E0 D1 → one pix_valid with op = 0, x = 0x10, y = 0x20, color = 0xE0; after pix_ready, tx_wr with tx_data = 0x06.
- Bad checksum: AA 01 10 20 E0 D2 → no pix_valid; tx_data = 0x15; err_cnt = 1.
- Range check: XMAX = 159, packet AA 01 A0 20 E0 61 → NAK 0x15; pix_valid never asserted.
- Clear plus backpressure: AA 02 00 00 1C 1E with pix_ready held low for 20 cycles → pix_valid = 1, op = 1, color = 0x1C, fields stable for all 20 cycles; ACK 0x06 issued only after the handshake.
- Error and timeout:
  - rx_error after AA 01 → rx_ack pulse, err_cnt += 1, return to IDLE.
  - With the macro defined, TIMEOUT_CYCLES = 100, AA 01 then 101 idle cycles → IDLE.
  - In both cases, a following valid packet is ACKed.
- Transmitter busy and reset: tx_busy = 1 during REPLY → tx_wr withheld until tx_busy = 0, then exactly one pulse; reset asserted in EXEC → pix_valid = 0 immediately, state IDLE.

Source files
------------

// File: rtl/uart_paint_cmd_if.sv
// Byte-level UART handshake, pixel request and error-count signals of the paint command decoder.
// master = decoder side, slave = UART / framebuffer / host side.
interface uart_paint_cmd_if;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_error;
  logic       rx_ack;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_busy;
  logic       pix_valid;
  logic       pix_op;
  logic [7:0] pix_x;
  logic [7:0] pix_y;
  logic [7:0] pix_color;
  logic       pix_ready;
  logic [7:0] err_cnt;

  modport master (
    input  rx_data, rx_avail, rx_error, tx_busy, pix_ready,
    output rx_ack, tx_data, tx_wr, pix_valid, pix_op, pix_x, pix_y, pix_color, err_cnt
  );

  modport slave (
    output rx_data, rx_avail, rx_error, tx_busy, pix_ready,
    input  rx_ack, tx_data, tx_wr, pix_valid, pix_op, pix_x, pix_y, pix_color, err_cnt
  );
endinterface

// File: rtl/uart_paint_cmd.sv
// Paint packet decoder (AA CMD X Y COLOR CSUM) issuing pixel/clear requests and ACK/NAK replies.
// Optional inter-byte timeout is compiled in with `define PAINT_CMD_TIMEOUT_EN.
module uart_paint_cmd #(
  parameter int XMAX           = 159,
  parameter int YMAX           = 119,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  uart_paint_cmd_if.master bus
);

  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_CLEAR = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  // Receiving states are contiguous so CMD..COLOR can advance by increment.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_X     = 3'd2,
    S_Y     = 3'd3,
    S_COLOR = 3'd4,
    S_CSUM  = 3'd5,
    S_EXEC  = 3'd6,
    S_REPLY = 3'd7
  } state_t;

  function automatic logic [7:0] pkt_csum(input logic [7:0] c, input logic [7:0] x,
                                          input logic [7:0] y, input logic [7:0] col);
    return c ^ x ^ y ^ col;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t     state_r, state_s;
  logic [7:0] cmd_r, x_r, y_r, color_r;
  logic       rx_ack_r, tx_wr_r, pix_valid_r, pix_op_r;
  logic [7:0] tx_data_r, pix_x_r, pix_y_r, pix_color_r, err_cnt_r;
  logic       receiving_s, err_evt_s, accept_s, pkt_ok_s, nak_s, timeout_s;
  logic       load_pix_s, enter_reply_s, send_s;

  assign receiving_s   = (state_r != S_EXEC) && (state_r != S_REPLY);
  assign err_evt_s     = bus.rx_error && !rx_ack_r;
  assign accept_s      = receiving_s && bus.rx_avail && !bus.rx_error && !rx_ack_r;
  assign pkt_ok_s      = (pkt_csum(cmd_r, x_r, y_r, color_r) == bus.rx_data) &&
                         ((cmd_r == CMD_CLEAR) ||
                          ((cmd_r == CMD_WRITE) && (x_r <= 8'(XMAX)) && (y_r <= 8'(YMAX))));
  assign load_pix_s    = (state_r == S_CSUM) && (state_s == S_EXEC);
  assign enter_reply_s = (state_s == S_REPLY) && (state_r != S_REPLY);
  // A fresh tx_wr is never issued back to back: the UART raises tx_busy one cycle late.
  assign send_s        = (state_s == S_REPLY) && !bus.tx_busy && !tx_wr_r;

`ifdef PAINT_CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_r;
  logic             counting_s;

  assign counting_s = (state_r != S_IDLE) && receiving_s;
  assign timeout_s  = counting_s && (tmo_r == TMO_W'(TIMEOUT_CYCLES));

  // Inter-byte idle counter, cleared on every accepted byte and outside a partial packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_r <= '0;
    end else if (counting_s && !accept_s && !timeout_s) begin
      tmo_r <= tmo_r + TMO_W'(1);
    end else begin
      tmo_r <= '0;
    end
  end
`else
  // No timeout: a partial packet waits indefinitely (term is false for any legal setting).
  assign timeout_s = (TIMEOUT_CYCLES < 0);
`endif

  // Next-state decode; an rx_error aborts a partial packet, EXEC/REPLY always complete.
  always_comb begin
    state_s = state_r;
    nak_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s && (bus.rx_data == SYNC_BYTE)) state_s = S_CMD;
        else                                        state_s = S_IDLE;
      end
      S_CMD, S_X, S_Y, S_COLOR: begin
        if (err_evt_s)      state_s = S_IDLE;
        else if (accept_s)  state_s = state_t'(state_r + 3'd1);
        else if (timeout_s) state_s = S_IDLE;
        else                state_s = state_r;
      end
      S_CSUM: begin
        if (err_evt_s) begin
          state_s = S_IDLE;
        end else if (accept_s) begin
          if (pkt_ok_s) begin
            state_s = S_EXEC;
          end else begin
            state_s = S_REPLY;
            nak_s   = 1'b1;
          end
        end else if (timeout_s) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_CSUM;
        end
      end
      S_EXEC: begin
        if (pix_valid_r && bus.pix_ready) state_s = S_REPLY;
        else                              state_s = S_EXEC;
      end
      S_REPLY: begin
        if (tx_wr_r) state_s = S_IDLE;
        else         state_s = S_REPLY;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State register and packet field capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cmd_r   <= 8'h00;
      x_r     <= 8'h00;
      y_r     <= 8'h00;
      color_r <= 8'h00;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        case (state_r)
          S_CMD:   cmd_r   <= bus.rx_data;
          S_X:     x_r     <= bus.rx_data;
          S_Y:     y_r     <= bus.rx_data;
          S_COLOR: color_r <= bus.rx_data;
          default: cmd_r   <= cmd_r;
        endcase
      end
    end
  end

  // Registered outputs: handshakes, pixel request fields, reply byte and error count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ack_r    <= 1'b0;
      tx_wr_r     <= 1'b0;
      tx_data_r   <= 8'h00;
      pix_valid_r <= 1'b0;
      pix_op_r    <= 1'b0;
      pix_x_r     <= 8'h00;
      pix_y_r     <= 8'h00;
      pix_color_r <= 8'h00;
      err_cnt_r   <= 8'h00;
    end else begin
      rx_ack_r    <= accept_s || err_evt_s;
      tx_wr_r     <= send_s;
      pix_valid_r <= (state_s == S_EXEC);
      if (enter_reply_s) begin
        tx_data_r <= (state_r == S_EXEC) ? ACK_BYTE : NAK_BYTE;
      end
      if (load_pix_s) begin
        pix_op_r    <= (cmd_r == CMD_CLEAR);
        pix_x_r     <= (cmd_r == CMD_CLEAR) ? 8'h00 : x_r;
        pix_y_r     <= (cmd_r == CMD_CLEAR) ? 8'h00 : y_r;
        pix_color_r <= color_r;
      end
      if (err_evt_s || nak_s) begin
        err_cnt_r <= sat_inc(err_cnt_r);
      end
    end
  end

  assign bus.rx_ack    = rx_ack_r;
  assign bus.tx_wr     = tx_wr_r;
  assign bus.tx_data   = tx_data_r;
  assign bus.pix_valid = pix_valid_r;
  assign bus.pix_op    = pix_op_r;
  assign bus.pix_x     = pix_x_r;
  assign bus.pix_y     = pix_y_r;
  assign bus.pix_color = pix_color_r;
  assign bus.err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_uart_paint_cmd.sv
// Directed bench for uart_paint_cmd: expected pixel requests and reply bytes are queued at
// stimulus time and compared when the DUT produces them.
module tb_uart_paint_cmd;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_paint_cmd_if bus();

  uart_paint_cmd #(.XMAX(159), .YMAX(119), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic       op;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] color;
  } pix_t;

  pix_t       pix_q[$];
  logic [7:0] tx_q[$];
  int checks = 0, passes = 0, fails = 0;
  int tx_count = 0, pix_count = 0, exp_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Scoreboard side: compare every reply and every completed pixel handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.tx_wr) begin
        tx_count++;
        chk("tx_expected", 32'(tx_q.size() != 0), 32'd1);
        if (tx_q.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(tx_q.pop_front()));
      end
      if (bus.pix_valid && bus.pix_ready) begin
        pix_t p;
        pix_count++;
        chk("pix_expected", 32'(pix_q.size() != 0), 32'd1);
        if (pix_q.size() != 0) begin
          p = pix_q.pop_front();
          chk("pix_op", 32'(bus.pix_op), 32'(p.op));
          chk("pix_color", 32'(bus.pix_color), 32'(p.color));
          if (!p.op) begin
            chk("pix_x", 32'(bus.pix_x), 32'(p.x));
            chk("pix_y", 32'(bus.pix_y), 32'(p.y));
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the rx_ack pulse.
  task automatic send_byte(input logic [7:0] b);
    bit acked = 1'b0;
    bus.rx_data  = b;
    bus.rx_avail = 1'b1;
    for (int i = 0; i < 50 && !acked; i++) begin
      @(negedge clk);
      acked = bus.rx_ack;
    end
    chk("rx_ack_seen", 32'(acked), 32'd1);
    @(negedge clk);
    chk("rx_ack_single", 32'(bus.rx_ack), 32'd0);
    bus.rx_avail = 1'b0;
  endtask

  task automatic send_err();
    bit acked = 1'b0;
    bus.rx_error = 1'b1;
    for (int i = 0; i < 50 && !acked; i++) begin
      @(negedge clk);
      acked = bus.rx_ack;
    end
    chk("err_ack_seen", 32'(acked), 32'd1);
    @(negedge clk);
    chk("err_ack_single", 32'(bus.rx_ack), 32'd0);
    bus.rx_error = 1'b0;
    if (exp_err < 255) exp_err++;
  endtask

  task automatic pkt(input logic [7:0] cmd, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] col, input logic [7:0] cs, input bit ok);
    if (ok) begin
      pix_q.push_back('{op: (cmd == 8'h02), x: x, y: y, color: col});
      tx_q.push_back(8'h06);
    end else begin
      tx_q.push_back(8'h15);
      if (exp_err < 255) exp_err++;
    end
    send_byte(8'hAA);
    send_byte(cmd);
    send_byte(x);
    send_byte(y);
    send_byte(col);
    send_byte(cs);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && (tx_q.size() != 0 || pix_q.size() != 0); i++) @(negedge clk);
    chk(tag, 32'(tx_q.size() + pix_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    chk("err_cnt", 32'(bus.err_cnt), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bit stable;
    bus.rx_data   = 8'h00;
    bus.rx_avail  = 1'b0;
    bus.rx_error  = 1'b0;
    bus.tx_busy   = 1'b0;
    bus.pix_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rx_ack", 32'(bus.rx_ack), 32'd0);
    chk("rst_tx_wr", 32'(bus.tx_wr), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
    chk("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
    chk("rst_pix_fields", {bus.pix_op, bus.pix_x, bus.pix_y, bus.pix_color}, 32'd0);
    chk("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
    reset = 1'b0;
    bus.pix_ready = 1'b1;
    @(negedge clk);

    // Noise before sync is dropped, then a valid write.
    send_byte(8'h00);
    send_byte(8'h55);
    pkt(8'h01, 8'h10, 8'h20, 8'hE0, 8'hD1, 1'b1);
    drain("valid_write");

    pkt(8'h01, 8'h10, 8'h20, 8'hE0, 8'hD2, 1'b0);  // bad checksum
    drain("bad_csum");
    pkt(8'h01, 8'hA0, 8'h20, 8'hE0, 8'h61, 1'b0);  // x = 160
    drain("x_range");
    pkt(8'h01, 8'h10, 8'h78, 8'h00, 8'h69, 1'b0);  // y = 120
    drain("y_range");
    pkt(8'h03, 8'h00, 8'h00, 8'h00, 8'h03, 1'b0);  // unknown command
    drain("bad_cmd");

    // Clear with 20 cycles of backpressure.
    bus.pix_ready = 1'b0;
    t0 = tx_count;
    pkt(8'h02, 8'h00, 8'h00, 8'h1C, 8'h1E, 1'b1);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!(bus.pix_valid === 1'b1 && bus.pix_op === 1'b1 && bus.pix_color === 8'h1C &&
            bus.tx_wr === 1'b0)) stable = 1'b0;
      @(negedge clk);
    end
    chk("bp_stable", 32'(stable), 32'd1);
    chk("bp_no_ack_yet", 32'(tx_count), 32'(t0));
    bus.pix_ready = 1'b1;
    drain("clear_bp");
    chk("bp_one_ack", 32'(tx_count), 32'(t0 + 1));

    // Boundary coordinates with the transmitter busy.
    bus.tx_busy = 1'b1;
    t0 = tx_count;
    pkt(8'h01, 8'h9F, 8'h77, 8'h00, 8'hE9, 1'b1);
    repeat (15) @(negedge clk);
    chk("busy_withheld", 32'(tx_count), 32'(t0));
    chk("busy_pending", 32'(tx_q.size()), 32'd1);
    bus.tx_busy = 1'b0;
    drain("busy_release");
    repeat (5) @(negedge clk);
    chk("busy_one_pulse", 32'(tx_count), 32'(t0 + 1));

    // rx_error mid-packet aborts silently.
    t0 = tx_count;
    send_byte(8'hAA);
    send_byte(8'h01);
    send_err();
    repeat (5) @(negedge clk);
    chk("err_no_reply", 32'(tx_count), 32'(t0));
    chk("err_cnt_after_err", 32'(bus.err_cnt), 32'(exp_err));
    pkt(8'h01, 8'h10, 8'h20, 8'hE0, 8'hD1, 1'b1);
    drain("after_error");

`ifdef PAINT_CMD_TIMEOUT_EN
    t0 = tx_count;
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (101) @(negedge clk);
    chk("tmo_no_reply", 32'(tx_count), 32'(t0));
    pkt(8'h01, 8'h10, 8'h20, 8'hE0, 8'hD1, 1'b1);
    drain("after_timeout");
`endif

    // Reset while the pixel request is pending.
    bus.pix_ready = 1'b0;
    pkt(8'h01, 8'h05, 8'h06, 8'h07, 8'h05, 1'b1);
    chk("exec_pix_valid", 32'(bus.pix_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_exec_pix_valid", 32'(bus.pix_valid), 32'd0);
    chk("rst_exec_fields", {bus.pix_op, bus.pix_x, bus.pix_y, bus.pix_color}, 32'd0);
    chk("rst_exec_err", 32'(bus.err_cnt), 32'd0);
    chk("rst_exec_tx", {bus.tx_wr, bus.tx_data}, 32'd0);
    pix_q.delete();
    tx_q.delete();
    exp_err = 0;
    @(negedge clk);
    reset = 1'b0;
    bus.pix_ready = 1'b1;
    @(negedge clk);
    pkt(8'h01, 8'h10, 8'h20, 8'hE0, 8'hD1, 1'b1);
    drain("after_reset");

    // err_cnt saturates at 255.
    for (int i = 0; i < 260; i++) send_err();
    repeat (2) @(negedge clk);
    chk("err_saturate", 32'(bus.err_cnt), 32'd255);

    chk("final_queues", 32'(tx_q.size() + pix_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
